// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 stream multiplexer.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // A 2-channel mux still needs one select bit, where $clog2(2) alone would
    // be fine but $clog2(1) would give a zero-width field.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: the first set request strictly after ptr, with
// wrap-around. The channel at ptr itself is searched last.
module rr_pick
    import mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int SEL_WIDTH = clog2_safe(NUM_CH)
) (
    input  logic [NUM_CH-1:0]    i_req,
    input  logic [SEL_WIDTH-1:0] i_ptr,
    output logic [SEL_WIDTH-1:0] o_grant,
    output logic                 o_grant_valid
);

    // Walk from ptr+1 upward; the first hit wins and later hits are ignored.
    always_comb begin
        o_grant       = '0;
        o_grant_valid = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!o_grant_valid && i_req[(int'(i_ptr) + i) % NUM_CH]) begin
                o_grant_valid = 1'b1;
                o_grant       = SEL_WIDTH'((int'(i_ptr) + i) % NUM_CH);
            end
        end
    end

endmodule

// File: rtl/mux_n_1_stream.sv
// Registered N:1 stream multiplexer with valid/ready on every channel.
// Fixed-select or round-robin arbitration; single-register output stage.
// Optional macro MUX_TRISTATE_EN: data output floats while Enable_In is low.
module mux_n_1_stream
    import mux_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4,
    localparam int SEL_WIDTH = clog2_safe(NUM_CH)
) (
    input  logic                         Clock_In,
    input  logic                         Reset_In,
    input  logic                         Enable_In,
    input  logic                         Mode_In,
    input  logic [SEL_WIDTH-1:0]         Select_In,
    input  logic [NUM_CH*DATA_WIDTH-1:0] Data_In,
    input  logic [NUM_CH-1:0]            Valid_In,
    output logic [NUM_CH-1:0]            Ready_Out,
    output logic [DATA_WIDTH-1:0]        MUX_Result_Data_Out,
    output logic                         Valid_Out,
    input  logic                         Ready_In,
    output logic [SEL_WIDTH-1:0]         Channel_Out
);

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic [SEL_WIDTH-1:0]  r_chan;
    logic [SEL_WIDTH-1:0]  r_ptr;

    logic [SEL_WIDTH-1:0]  w_rr_grant;
    logic                  w_rr_grant_vld;
    logic [SEL_WIDTH-1:0]  w_grant;
    logic                  w_grant_vld;
    logic                  w_slot_free;
    logic [NUM_CH-1:0]     w_ready;
    logic                  w_xfer;
    logic [DATA_WIDTH-1:0] w_data_sel;

    rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
        .i_req         (Valid_In),
        .i_ptr         (r_ptr),
        .o_grant       (w_rr_grant),
        .o_grant_valid (w_rr_grant_vld)
    );

    // Grant selection: fixed mode routes Select_In (if in range) whether or not
    // that channel is valid; there is deliberately no fallback to other channels.
    always_comb begin
        w_grant     = w_rr_grant;
        w_grant_vld = w_rr_grant_vld;
        if (Mode_In == MODE_FIXED) begin
            w_grant     = Select_In;
            w_grant_vld = ({1'b0, Select_In} < (SEL_WIDTH+1)'(NUM_CH));
        end
    end

    // Output slot accepts a word when empty or draining this cycle. Ready is
    // also held off during reset, since any word taken then would be dropped.
    always_comb begin
        w_slot_free = !r_valid || Ready_In;
        w_ready     = '0;
        if (Enable_In && w_grant_vld && w_slot_free && !Reset_In)
            w_ready = NUM_CH'(1) << w_grant;
        w_xfer     = |(Valid_In & w_ready);
        w_data_sel = Data_In[w_grant*DATA_WIDTH +: DATA_WIDTH];
    end

    // Output register and round-robin pointer; the pointer only moves on an
    // RR-mode transfer so fixed-mode traffic does not disturb fairness.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_chan  <= '0;
            r_ptr   <= '0;
        end else if (w_xfer) begin
            r_data  <= w_data_sel;
            r_valid <= 1'b1;
            r_chan  <= w_grant;
            if (Mode_In == MODE_RR)
                r_ptr <= w_grant;
        end else if (Ready_In) begin
            r_valid <= 1'b0;
        end
    end

    assign Ready_Out   = w_ready;
    assign Valid_Out   = r_valid;
    assign Channel_Out = r_chan;

`ifdef MUX_TRISTATE_EN
    assign MUX_Result_Data_Out = Enable_In ? r_data : 'z;
`else
    assign MUX_Result_Data_Out = r_data;
`endif

endmodule

// File: tb/tb_mux_n_1_stream.sv
// Directed self-checking bench for mux_n_1_stream (4-channel and 3-channel builds).
module tb_mux_n_1_stream;

    logic        clk = 1'b0;
    logic        rst, en, mode, rdy_in;
    logic [1:0]  sel;
    logic [31:0] din;
    logic [3:0]  vin, rdy_out;
    logic [7:0]  dout;
    logic        vout;
    logic [1:0]  chan;

    logic        en3, mode3, rdy_in3;
    logic [1:0]  sel3;
    logic [23:0] din3;
    logic [2:0]  vin3, rdy_out3;
    logic [7:0]  dout3;
    logic        vout3;
    logic [1:0]  chan3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_n_1_stream #(.DATA_WIDTH(8), .NUM_CH(4)) dut (
        .Clock_In(clk), .Reset_In(rst), .Enable_In(en), .Mode_In(mode),
        .Select_In(sel), .Data_In(din), .Valid_In(vin), .Ready_Out(rdy_out),
        .MUX_Result_Data_Out(dout), .Valid_Out(vout), .Ready_In(rdy_in),
        .Channel_Out(chan)
    );

    mux_n_1_stream #(.DATA_WIDTH(8), .NUM_CH(3)) dut3 (
        .Clock_In(clk), .Reset_In(rst), .Enable_In(en3), .Mode_In(mode3),
        .Select_In(sel3), .Data_In(din3), .Valid_In(vin3), .Ready_Out(rdy_out3),
        .MUX_Result_Data_Out(dout3), .Valid_Out(vout3), .Ready_In(rdy_in3),
        .Channel_Out(chan3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 1; mode = 0; sel = 2'd2; vin = 4'b1111; rdy_in = 1;
        din = 32'hFFFF_FFFF;
        en3 = 1; mode3 = 0; sel3 = 2'd0; vin3 = 3'b111; rdy_in3 = 1; din3 = 24'hFFFFFF;
        tick(); tick();
        checks++; if (vout !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", vout); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", dout); end
        checks++; if (chan !== 2'd0) begin errors++; $display("FAIL reset_chan: got %0d expected 0", chan); end
        checks++; if (rdy_out !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", rdy_out); end
        checks++; if (vout3 !== 1'b0) begin errors++; $display("FAIL reset_valid3: got %b expected 0", vout3); end
        en3 = 0;
        rst = 0;
    endtask

    task automatic test_fixed();
        mode = 0; sel = 2'd2; vin = 4'b1111; rdy_in = 1; en = 1;
        din = {8'h44, 8'hA5, 8'h22, 8'h11};
        #1;
        checks++; if (rdy_out !== 4'b0100) begin errors++; $display("FAIL fixed_ready: got %b expected 0100", rdy_out); end
        tick();
        checks++; if (dout !== 8'hA5 || chan !== 2'd2 || vout !== 1'b1) begin
            errors++; $display("FAIL fixed_word1: got %h/%0d/%b expected a5/2/1", dout, chan, vout); end
        checks++; if (rdy_out !== 4'b0100) begin errors++; $display("FAIL fixed_stream_ready: got %b expected 0100", rdy_out); end
        din = {8'h44, 8'h5A, 8'h22, 8'h11};
        tick();
        checks++; if (dout !== 8'h5A || chan !== 2'd2 || vout !== 1'b1) begin
            errors++; $display("FAIL fixed_word2: got %h/%0d/%b expected 5a/2/1", dout, chan, vout); end
    endtask

    task automatic test_rr();
        logic [1:0] exp_a [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [1:0] exp_b [4] = '{2'd3, 2'd0, 2'd3, 2'd0};
        mode = 1; vin = 4'b1111; rdy_in = 1;
        din = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (chan !== exp_a[i] || dout !== (8'h10 + 8'(exp_a[i])) || vout !== 1'b1) begin
                errors++; $display("FAIL rr_all[%0d]: got ch%0d/%h expected ch%0d/%h", i, chan, dout, exp_a[i], 8'h10 + 8'(exp_a[i])); end
        end
        vin = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (chan !== exp_b[i] || vout !== 1'b1) begin
                errors++; $display("FAIL rr_1001[%0d]: got ch%0d expected ch%0d", i, chan, exp_b[i]); end
        end
    endtask

    task automatic test_backpressure();
        // held word is ch0 data 10, pointer at 0
        vin = 4'b1111; rdy_in = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (rdy_out !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0000", i, rdy_out); end
            tick();
            checks++; if (dout !== 8'h10 || chan !== 2'd0 || vout !== 1'b1) begin
                errors++; $display("FAIL bp_hold[%0d]: got %h/%0d/%b expected 10/0/1", i, dout, chan, vout); end
        end
        rdy_in = 1;
        #1;
        checks++; if (rdy_out !== 4'b0010) begin errors++; $display("FAIL bp_release_ready: got %b expected 0010", rdy_out); end
        tick();
        checks++; if (dout !== 8'h11 || chan !== 2'd1 || vout !== 1'b1) begin
            errors++; $display("FAIL bp_no_bubble: got %h/%0d/%b expected 11/1/1", dout, chan, vout); end
    endtask

    task automatic test_enable();
        en = 0; rdy_in = 1;
        #1;
        checks++; if (rdy_out !== 4'b0000) begin errors++; $display("FAIL en_ready: got %b expected 0000", rdy_out); end
        tick();
        checks++; if (vout !== 1'b0) begin errors++; $display("FAIL en_drain: got %b expected 0", vout); end
        tick();
        checks++; if (vout !== 1'b0) begin errors++; $display("FAIL en_no_accept: got %b expected 0", vout); end
`ifdef MUX_TRISTATE_EN
        checks++; if (dout !== 8'hzz) begin errors++; $display("FAIL en_tristate: got %h expected zz", dout); end
`else
        checks++; if (dout !== 8'h11) begin errors++; $display("FAIL en_held_visible: got %h expected 11", dout); end
`endif
        en = 1;
    endtask

    task automatic test_fixed_novalid();
        mode = 0; sel = 2'd1; vin = 4'b1101; rdy_in = 1;
        #1;
        checks++; if (rdy_out !== 4'b0010) begin errors++; $display("FAIL nv_ready: got %b expected 0010", rdy_out); end
        tick();
        checks++; if (vout !== 1'b0) begin errors++; $display("FAIL nv_no_fallback: got %b expected 0", vout); end
    endtask

    task automatic test_sel_oob();
        en3 = 1; mode3 = 0; sel3 = 2'd3; vin3 = 3'b111; rdy_in3 = 1;
        din3 = {8'hC2, 8'hC1, 8'hC0};
        #1;
        checks++; if (rdy_out3 !== 3'b000) begin errors++; $display("FAIL oob_ready: got %b expected 000", rdy_out3); end
        tick();
        checks++; if (vout3 !== 1'b0) begin errors++; $display("FAIL oob_no_xfer: got %b expected 0", vout3); end
        sel3 = 2'd1;
        #1;
        checks++; if (rdy_out3 !== 3'b010) begin errors++; $display("FAIL n3_ready: got %b expected 010", rdy_out3); end
        tick();
        checks++; if (dout3 !== 8'hC1 || chan3 !== 2'd1 || vout3 !== 1'b1) begin
            errors++; $display("FAIL n3_word: got %h/%0d/%b expected c1/1/1", dout3, chan3, vout3); end
    endtask

    task automatic test_reset_mid();
        // leave pointer at 3 via an RR transfer, then hold a word under backpressure
        mode = 1; vin = 4'b1000; rdy_in = 0; din = {8'h77, 8'h66, 8'h55, 8'h44};
        tick();
        checks++; if (vout !== 1'b1 || chan !== 2'd3 || dout !== 8'h77) begin
            errors++; $display("FAIL rm_held: got %b/%0d/%h expected 1/3/77", vout, chan, dout); end
        rst = 1;
        tick();
        rst = 0;
        checks++; if (vout !== 1'b0 || chan !== 2'd0 || dout !== 8'h00) begin
            errors++; $display("FAIL rm_dropped: got %b/%0d/%h expected 0/0/00", vout, chan, dout); end
        vin = 4'b1111; rdy_in = 1;
        #1;
        checks++; if (rdy_out !== 4'b0010) begin errors++; $display("FAIL rm_ptr_reset: got %b expected 0010", rdy_out); end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr();
        test_backpressure();
        test_enable();
        test_fixed_novalid();
        test_sel_oob();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
